generador_sensores: RTL
=======================

GENERADOR_SENSORES -- requirements
Module: generador_sensores

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8: width of the per-phase dwell count.
REQ-002 The block SHALL have port clk, input, 1: single clock, all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1: request one vehicle sequence, sampled only in IDLE.
REQ-005 The block SHALL have port dir, input, 1: 0 = entry sequence, 1 = exit sequence, latched with start.
REQ-006 The block SHALL have port dwell, input, DWELL_W: each phase lasts dwell+1 cycles, latched with start.
REQ-007 The block SHALL have port abort, input, 1: cancel the running sequence.
REQ-008 The block SHALL have port backout, input, 1: vehicle reverses at the AB phase; active only with GEN_BACKOUT_EN.
REQ-009 The block SHALL have port sensor, output, 2: bit1 = sensor A, bit0 = sensor B; feeds the parking detector's sensor input.
REQ-010 The block SHALL have port busy, output, 1: sequence in progress.
REQ-011 The block SHALL have port done, output, 1: one-cycle pulse when a full sequence completes.
REQ-012 The block SHALL have port aborted, output, 1: one-cycle pulse when a sequence ends by abort or backout.

Function
REQ-013 States SHALL be IDLE, PH1, PH2, PH3, PH4, plus RB1 and RB2 when GEN_BACKOUT_EN is defined.
REQ-014 Entry patterns PH1..PH4 SHALL be 10, 11, 01, 00; exit patterns SHALL be 01, 11, 10, 00.
REQ-015 sensor SHALL be registered and equal 00 in IDLE.
REQ-016 On the edge that samples start=1 in IDLE, the block SHALL latch dir and dwell, enter PH1, drive the PH1 pattern and set busy=1.
REQ-017 Each phase SHALL hold its pattern for exactly latched dwell+1 cycles, counted by a DWELL_W-bit down-counter; dwell=0 gives 1 cycle per phase and all-ones gives 2^DWELL_W cycles.
REQ-018 Changes on dir or dwell while busy SHALL be ignored.
REQ-019 On the edge ending PH4, the block SHALL enter IDLE with busy=0, sensor=00 and done=1 for exactly that one cycle.
REQ-020 start while busy=1 SHALL be ignored and not queued.
REQ-021 start=1 in the cycle where done=1 SHALL be accepted, allowing back-to-back sequences with no idle gap beyond the done cycle.
REQ-022 abort=1 while busy SHALL take priority over phase advance and backout: on the next edge go to IDLE, sensor=00, busy=0, aborted=1 for one cycle, and done stays 0.
REQ-023 abort in IDLE SHALL be ignored.
REQ-024 abort and start together in IDLE SHALL give start priority.
REQ-025 done and aborted SHALL never be high in the same cycle.

Reset
REQ-026 While reset=0, asynchronously: state=IDLE, sensor=00, busy=0, done=0, aborted=0, counter=0, latched dir/dwell=0.
REQ-027 Reset asserted mid-sequence SHALL discard the sequence with no done or aborted pulse.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 With macro GEN_BACKOUT_EN defined, backout=1 sampled on the edge ending PH2 SHALL route PH2 -> RB1 -> RB2 -> IDLE.
REQ-030 RB1 SHALL drive the PH1 pattern and RB2 SHALL drive 00, each for dwell+1 cycles.
REQ-031 On entering IDLE from RB2, aborted SHALL pulse for one cycle and done SHALL stay 0.
REQ-032 backout at any other time SHALL be ignored.
REQ-033 abort SHALL still apply during RB1 and RB2.
REQ-034 Without GEN_BACKOUT_EN, the backout port SHALL exist but be ignored, RB1/RB2 SHALL not be built, and behaviour SHALL equal REQ-013..REQ-025.

Verification
REQ-035 Scenario: dir=0, dwell=0, start at edge 0 -> sensor 10/11/01/00 after edges 0..3; done=1 and busy=0 after edge 4 for one cycle.
REQ-036 Scenario: dir=1, dwell=2 -> sensor 01,11,10,00 each held 3 cycles; done after edge 12; dwell changed to 5 mid-run has no effect.
REQ-037 Scenario: start held high through done -> second sequence's first pattern appears the cycle after done; start pulses during busy create no extra sequence.
REQ-038 Scenario: dwell=1, abort=1 during PH3 -> next edge sensor=00, busy=0, aborted=1 for one cycle, done never 1.
REQ-039 Scenario: GEN_BACKOUT_EN, dir=0, dwell=0, backout=1 during PH2 -> sensor 10,11,10,00, then aborted pulse; without macro -> normal 10,11,01,00 and done.
REQ-040 Scenario: reset driven low mid-PH2 between edges -> sensor=00 and busy=0 immediately, with no pulse after release.

Source files
------------

// File: rtl/generador_sensores.sv
`default_nettype none
// ============================================================================
// Module      : generador_sensores
// Description : Vehicle sensor-pattern generator. On start it plays a
//               four-phase A/B sensor sequence (entry or exit), each phase held
//               for dwell+1 cycles, then pulses done. abort cancels a running
//               sequence and pulses aborted.
//               Optional feature macro GEN_BACKOUT_EN: a vehicle reversing at
//               the AB phase (backout sampled on the edge ending PH2) replays
//               PH1 and then 00 before returning to idle with an aborted pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module generador_sensores #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               abort,
    input  logic               backout,
    output logic [1:0]         sensor,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_PH2  = 3'd2,
        ST_PH3  = 3'd3,
        ST_PH4  = 3'd4
`ifdef GEN_BACKOUT_EN
        ,
        ST_RB1  = 3'd5,
        ST_RB2  = 3'd6
`endif
    } state_t;

    localparam logic [DWELL_W-1:0] c_cnt_one = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dir_q, dir_d;
    logic [1:0]         sensor_q, sensor_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

`ifndef GEN_BACKOUT_EN
    // backout has no effect unless the reversing feature is built
    logic backout_unused;
    assign backout_unused = backout;
`endif

    // Sensor pattern for a state; exit sequence is the entry one with A/B swapped
    function automatic logic [1:0] phase_pattern(input state_t s, input logic d);
        logic [1:0] p;
        case (s)
            ST_PH1:  p = 2'b10;
`ifdef GEN_BACKOUT_EN
            ST_RB1:  p = 2'b10;
`endif
            ST_PH2:  p = 2'b11;
            ST_PH3:  p = 2'b01;
            default: p = 2'b00;
        endcase
        return d ? {p[0], p[1]} : p;
    endfunction

    // Next-state logic: start in idle, abort first, then dwell countdown, then advance
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        dir_d     = dir_q;
        sensor_d  = sensor_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        if (state_q == ST_IDLE) begin
            // abort is irrelevant here, so start alone decides
            if (start) begin
                dir_d    = dir;
                dwell_d  = dwell;
                cnt_d    = dwell;
                state_d  = ST_PH1;
                sensor_d = phase_pattern(ST_PH1, dir);
                busy_d   = 1'b1;
            end
        end else if (abort) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            sensor_d  = 2'b00;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - c_cnt_one;
        end else begin
            cnt_d = dwell_q;
            case (state_q)
                ST_PH1: state_d = ST_PH2;
`ifdef GEN_BACKOUT_EN
                ST_PH2: state_d = backout ? ST_RB1 : ST_PH3;
                ST_RB1: state_d = ST_RB2;
                ST_RB2: begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end
`else
                ST_PH2: state_d = ST_PH3;
`endif
                ST_PH3: state_d = ST_PH4;
                ST_PH4: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_d == ST_IDLE) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end
            sensor_d = phase_pattern(state_d, dir_q);
        end
    end

    // State and output registers, cleared asynchronously by active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dwell_q   <= '0;
            dir_q     <= 1'b0;
            sensor_q  <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dwell_q   <= dwell_d;
            dir_q     <= dir_d;
            sensor_q  <= sensor_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign sensor  = sensor_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule
`default_nettype wire
